// File: rtl/trace_packer_pkg.sv
// trace_packer_pkg -- shared Tracer/Logger store-interface constants and trace FSM states.
// Revision 1.0
`default_nettype none

package trace_packer_pkg;

  localparam int TRB_WIDTH          = 64;
  localparam int TRB_NTRACE_BITS    = $clog2($clog2(TRB_WIDTH) + 1);
  localparam int TRB_EVENT_POS_BITS = $clog2(TRB_WIDTH);

  typedef enum logic [1:0] {
    ARMED     = 2'd0,
    TRIGGERED = 2'd1,
    STOPPED   = 2'd2
  } trace_state_t;

endpackage

`default_nettype wire

// File: rtl/trace_packer_if.sv
// trace_packer_if -- probe sample input, Logger control and store handshake bundle.
// Revision 1.0
`default_nettype none

interface trace_packer_if;
  import trace_packer_pkg::*;

  logic [TRB_WIDTH-1:0]          trace;
  logic                          trace_valid;
  logic                          trigger;
  logic                          mode;
  logic [TRB_NTRACE_BITS-1:0]    ntrace;
  logic                          trg_delayed;
  logic [TRB_WIDTH-1:0]          data;
  logic                          store;
  logic                          store_perm;
  logic [TRB_EVENT_POS_BITS-1:0] event_pos;
  logic                          trg_event;
  logic                          overflow;

  modport slave (
    input  trace, trace_valid, trigger, mode, ntrace, trg_delayed, store_perm,
    output data, store, event_pos, trg_event, overflow
  );

  modport master (
    output trace, trace_valid, trigger, mode, ntrace, trg_delayed, store_perm,
    input  data, store, event_pos, trg_event, overflow
  );

endinterface

`default_nettype wire

// File: rtl/trace_packer.sv
// trace_packer -- packs 2**ntrace-bit samples into words for the Logger, tracks first trigger.
// Revision 1.0
`default_nettype none

module trace_packer
  import trace_packer_pkg::*;
(
  input  wire logic      clk,
  input  wire logic      rst_n,
  trace_packer_if.slave  bus
);

  localparam int                         POS_BITS = TRB_EVENT_POS_BITS;
  localparam logic [TRB_NTRACE_BITS-1:0] NT_MAX   = TRB_NTRACE_BITS'(POS_BITS);
  localparam logic [POS_BITS:0]          ONE_W    = 1;

  trace_state_t               state, state_nx;
  logic [TRB_WIDTH-1:0]       fill_reg, hold_data;
  logic [POS_BITS-1:0]        fill_cnt, event_pos;
  logic                       fill_trig, hold_valid, hold_trig, overflow;
  logic [TRB_NTRACE_BITS-1:0] ntrace_q;

  logic [TRB_NTRACE_BITS-1:0] nt;
  logic [POS_BITS-1:0]        k, last_idx, pos;
  logic [POS_BITS:0]          lane_w;
  logic [TRB_WIDTH-1:0]       lane_mask, word_nx;
  logic width_chg, accept, trig_take, stop_now, word_done, word_trig, handoff, hold_free;

  // A width change restarts the word, so the sample arriving with it lands at slot 0.
  always_comb begin
    nt        = (bus.ntrace > NT_MAX) ? NT_MAX : bus.ntrace;
    width_chg = (bus.ntrace != ntrace_q);
    k         = width_chg ? '0 : fill_cnt;
    last_idx  = POS_BITS'((TRB_WIDTH >> nt) - 1);
    pos       = k << nt;
    lane_w    = ONE_W << nt;
    lane_mask = ~({TRB_WIDTH{1'b1}} << lane_w);
    accept    = bus.trace_valid && (state != STOPPED);
    trig_take = accept && bus.trigger && (state == ARMED);
    stop_now  = (state == TRIGGERED) && bus.mode && bus.trg_delayed;
    word_done = accept && (k == last_idx);
    word_nx   = (width_chg ? '0 : fill_reg) | ((bus.trace & lane_mask) << pos);
    word_trig = (fill_trig && !width_chg) || trig_take;
    handoff   = hold_valid && bus.store_perm;
    hold_free = !hold_valid || handoff;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ARMED:     if (trig_take) state_nx = TRIGGERED;
      TRIGGERED: if (stop_now)  state_nx = STOPPED;
      STOPPED:   state_nx = STOPPED;
      default:   state_nx = ARMED;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ARMED;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_reg   <= '0;
      fill_cnt   <= '0;
      fill_trig  <= 1'b0;
      hold_data  <= '0;
      hold_valid <= 1'b0;
      hold_trig  <= 1'b0;
      event_pos  <= '0;
      overflow   <= 1'b0;
      ntrace_q   <= '0;
    end else begin
      ntrace_q <= bus.ntrace;

      if (stop_now || word_done || (width_chg && !accept)) begin
        fill_reg  <= '0;
        fill_cnt  <= '0;
        fill_trig <= 1'b0;
      end else if (accept) begin
        fill_reg  <= word_nx;
        fill_cnt  <= k + 1'b1;
        fill_trig <= word_trig;
      end

      if (trig_take) event_pos <= pos;

      // A completed word may enter the holding register on the same edge it drains.
      if (word_done && hold_free) begin
        hold_data  <= word_nx;
        hold_valid <= 1'b1;
        hold_trig  <= word_trig;
      end else if (handoff) begin
        hold_valid <= 1'b0;
        hold_trig  <= 1'b0;
      end

      if (word_done && !hold_free) overflow <= 1'b1;
    end
  end

  assign bus.data      = hold_data;
  assign bus.store     = hold_valid;
  assign bus.event_pos = event_pos;
  assign bus.trg_event = handoff && hold_trig;
  assign bus.overflow  = overflow;

endmodule

`default_nettype wire
